// File: rtl/subtractor_pkg.sv
// Shared types and width helpers for the signed serial subtractor and its
// combinational adder sibling.
package subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One guard bit above the wider operand makes overflow impossible.
  function automatic int default_wlout(input int wl1, input int wl2);
    return (wl1 > wl2) ? wl1 + 1 : wl2 + 1;
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Single full-adder cell; the only arithmetic in the bit-serial datapath.
module serial_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/signed_serial_subtractor.sv
// Bit-serial signed subtractor: out = in1 - in2, LSB first, one bit per clock.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | shifting one result bit per clock
// DONE  | one-cycle done pulse; start here chains the next operation
module signed_serial_subtractor
  import subtractor_pkg::*;
#(
  parameter int WLin1 = 2,
  parameter int WLin2 = 2,
  parameter int WLout = default_wlout(WLin1, WLin2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WLin1-1:0] in1,
  input  logic [WLin2-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WLout-1:0] out
);

  localparam int              CW   = $clog2(WLout) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WLout - 1);

  state_e           state_q, state_d;
  logic [WLout-1:0] a_q, a_d;
  logic [WLout-1:0] b_q, b_d;
  logic [WLout-1:0] res_q, res_d;
  logic [WLout-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             fa_s, fa_cout;

  serial_fa_cell u_fa (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .cin_i (carry_q),
    .s_o   (fa_s),
    .cout_o(fa_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          a_d     = {{(WLout - WLin1){in1[WLin1-1]}}, in1};
          // Subtraction as a + ~b + 1: the +1 enters through the initial carry.
          b_d     = ~{{(WLout - WLin2){in2[WLin2-1]}}, in2};
          carry_d = 1'b1;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      RUN: begin
        a_d     = {1'b0, a_q[WLout-1:1]};
        b_d     = {1'b0, b_q[WLout-1:1]};
        carry_d = fa_cout;
        res_d   = {fa_s, res_q[WLout-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          out_d   = res_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign out  = out_q;

endmodule

// File: tb/tb_signed_serial_subtractor.sv
// Self-checking bench: default-width and 4/2-bit instances against plain integer subtraction.
module tb_signed_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [1:0] in1_0 = '0, in2_0 = '0;
  logic [3:0] in1_1 = '0;
  logic [1:0] in2_1 = '0;
  logic busy0, done0, busy1, done1;
  logic [2:0] out0;
  logic [4:0] out1;

  int sel = 0;
  logic busy_m, done_m;
  logic signed [4:0] out_m;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int sel;
    int a;
    int b;
    int exp;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  signed_serial_subtractor dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .in1(in1_0), .in2(in2_0),
    .busy(busy0), .done(done0), .out(out0)
  );

  signed_serial_subtractor #(.WLin1(4), .WLin2(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in1(in1_1), .in2(in2_1),
    .busy(busy1), .done(done1), .out(out1)
  );

  always_comb begin
    busy_m = busy0;
    done_m = done0;
    out_m  = {{2{out0[2]}}, out0};
    if (sel == 1) begin
      busy_m = busy1;
      done_m = done1;
      out_m  = out1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int s, input int a, input int b, input logic st);
    if (s == 0) begin
      in1_0 = 2'(a); in2_0 = 2'(b); start0 = st;
    end else begin
      in1_1 = 4'(a); in2_1 = 2'(b); start1 = st;
    end
  endtask

  task automatic do_op(input int s, input int a, input int b, input int exp, input string name);
    int wl;
    int k;
    wl  = (s == 1) ? 5 : 3;
    sel = s;
    @(negedge clk);
    drive(s, a, b, 1'b1);
    @(posedge clk);
    #1;
    drive(s, int'($urandom), int'($urandom), 1'b0);
    chk({name, " busy_after_accept"}, int'(busy_m), 1);
    k = 0;
    while (k < 20) begin
      @(posedge clk);
      #1;
      k++;
      if (done_m) break;
      chk({name, " busy_in_run"}, int'(busy_m), 1);
    end
    chk({name, " latency"}, k, wl);
    chk({name, " busy_at_done"}, int'(busy_m), 0);
    chk({name, " out"}, int'(out_m), exp);
    @(posedge clk);
    #1;
    chk({name, " done_width"}, int'(done_m), 0);
    chk({name, " out_held"}, int'(out_m), exp);
  endtask

  initial begin
    tbl[0] = '{0, -2,  1, -3};
    tbl[1] = '{0,  1, -2,  3};
    tbl[2] = '{0, -2, -2,  0};
    tbl[3] = '{0,  1,  1,  0};
    tbl[4] = '{1, -8,  1, -9};
    tbl[5] = '{1,  7, -2,  9};
    tbl[6] = '{1, -8, -2, -6};
    tbl[7] = '{1,  0,  1, -1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset out0", int'(out0), 0);
    chk("reset busy0", int'(busy0), 0);
    chk("reset done0", int'(done0), 0);
    chk("reset out1", int'(out1), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      do_op(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("table%0d", i));

    for (int a = -2; a <= 1; a++)
      for (int b = -2; b <= 1; b++)
        do_op(0, a, b, a - b, $sformatf("sweep a=%0d b=%0d", a, b));

    for (int i = 0; i < 20; i++) begin
      int a, b;
      a = int'($urandom_range(0, 15)) - 8;
      b = int'($urandom_range(0, 3)) - 2;
      do_op(1, a, b, a - b, $sformatf("rand a=%0d b=%0d", a, b));
    end

    // Back-to-back: start held, garbage on inputs and start during RUN.
    sel = 0;
    @(negedge clk);
    drive(0, 1, 1, 1'b1);
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      if (k == 3 || k == 7) begin
        chk($sformatf("b2b done k=%0d", k), int'(done0), 1);
        chk($sformatf("b2b busy k=%0d", k), int'(busy0), 0);
        chk($sformatf("b2b out k=%0d", k), int'(out_m), (k == 3) ? 0 : -1);
      end else begin
        chk($sformatf("b2b done k=%0d", k), int'(done0), 0);
        chk($sformatf("b2b busy k=%0d", k), int'(busy0), 1);
      end
      if (k == 3)
        drive(0, 0, 1, 1'b1);
      else if (k < 7)
        drive(0, int'($urandom), int'($urandom), 1'($urandom_range(0, 1)));
      else
        drive(0, 0, 0, 1'b0);
    end
    @(posedge clk);
    #1;
    chk("b2b done_after", int'(done0), 0);

    // Reset two cycles into an operation, with a nonzero result on out.
    do_op(0, -2, 1, -3, "pre_reset");
    @(negedge clk);
    drive(0, 1, -2, 1'b1);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset out0", int'(out0), 0);
    chk("midrun_reset busy0", int'(busy0), 0);
    chk("midrun_reset done0", int'(done0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_reset done k=%0d", k), int'(done0), 0);
      chk($sformatf("post_reset busy k=%0d", k), int'(busy0), 0);
    end
    do_op(0, 1, -2, 3, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
